y_seq_ctrl: RTL and testbench
=============================

Y_SEQ_CTRL -- requirements
Module: y_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, run request, sampled in IDLE only.
REQ-004 SHALL have port entry, input, 32, entry PC loaded on accepted start.
REQ-005 SHALL have port count, input, 8, number of instructions to run, sampled with start.
REQ-006 SHALL have port ins, input, 32, instruction from fetch stage.
REQ-007 SHALL have port pcp4, input, 32, PC+4 from fetch stage.
REQ-008 SHALL have port imm, input, 32, sign-extended immediate from decode stage.
REQ-009 SHALL have port zero, input, 1, ALU zero flag.
REQ-010 SHALL have port pc, output, 32, current PC driven to fetch.
REQ-011 SHALL have port if_en, output, 1, instruction-register load strobe.
REQ-012 SHALL have ports reg_dst, alu_src, reg_we, each output, 1, datapath controls.
REQ-013 SHALL have port alu_op, output, 3, ALU operation select.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port retired, output, 8, instructions completed in current/last run.

Function
REQ-017 SHALL implement states IDLE, FETCH, DECODE, EXEC, WB; each non-IDLE state lasts exactly 1 cycle, so 4 cycles per instruction.
REQ-018 IDLE: start=1 and count!=0 SHALL load pc<=entry, remaining<=count, retired<=0, go to FETCH.
REQ-019 IDLE: start=1 and count==0 SHALL pulse done next cycle, set retired<=0, stay IDLE.
REQ-020 start while busy SHALL be ignored.
REQ-021 FETCH: if_en=1 for this cycle only; next DECODE.
REQ-022 DECODE SHALL register controls from ins[31:26]: 0 (R) -> reg_dst=1, alu_src=0, wr=1, alu_op=010; 2 (j) -> reg_dst=0, alu_src=1, wr=0, alu_op=010; 4 (beq) -> reg_dst=0, alu_src=0, wr=0, alu_op=110; 43 (sw) -> reg_dst=0, alu_src=1, wr=0, alu_op=010; 63 (halt) -> all controls 0, wr=0; any other -> reg_dst=0, alu_src=1, wr=1, alu_op=010.
REQ-023 Registered reg_dst/alu_src/alu_op SHALL hold stable from DECODE+1 through WB; they SHALL read 0 in IDLE.
REQ-024 EXEC: no output changes except state; next WB.
REQ-025 WB: reg_we SHALL equal decoded wr for this cycle only; reg_we=0 in all other states.
REQ-026 WB next-PC: beq and zero=1 -> pcp4 + {imm[29:0],2'b00} (32-bit, wraps modulo 2^32); j -> {pcp4[31:28], ins[25:0], 2'b00}; otherwise pcp4.
REQ-027 WB SHALL increment retired (saturating at 255) and decrement remaining.
REQ-028 WB exit: halt opcode or remaining reaching 0 -> IDLE with done=1 on the first IDLE cycle; else FETCH.
REQ-029 Halt SHALL count as retired; pc SHALL still update to pcp4.
REQ-030 done and if_en SHALL never be high in the same cycle.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, pc=0, remaining=0, retired=0, all control outputs, busy, done, if_en = 0, regardless of state.
REQ-032 Reset mid-run SHALL abandon the instruction with no reg_we pulse and no done pulse; operation resumes only on a new start after rst_n=1.

Verification
REQ-033 entry=128, count=3, three R-type ins -> if_en at cycles 1,5,9; reg_we at cycles 4,8,12; pc 128->132->136->140; done at cycle 13; retired=3.
REQ-034 beq (op 4) with zero=1, pcp4=136, imm=2 -> pc=144, reg_we stays 0, alu_op=110, alu_src=0.
REQ-035 j (op 2), pcp4=0x00000084, ins[25:0]=0x000020 -> pc=0x00000080, reg_we 0.
REQ-036 count=10, halt (op 63) as 2nd instruction -> done after 2nd WB, retired=2, busy falls.
REQ-037 start with count=0 -> done pulse 1 cycle later, busy never asserts, retired=0.
REQ-038 rst_n low during EXEC of 2nd of 3 instructions -> outputs zero same cycle, no reg_we/done; new start then runs normally from entry.

Source files
------------

// File: rtl/y_seq_ctrl.sv
// -----------------------------------------------------------------------------
// y_seq_ctrl
//   Multi-cycle instruction sequencer. After an accepted start it runs `count`
//   instructions from `entry`, four cycles each (FETCH, DECODE, EXEC, WB). It
//   drives the PC to fetch, registers the datapath controls decoded from the
//   opcode, and steps the PC at write-back. A halt opcode ends the run early.
//
// Ports
//   clk, rst_n         single rising-edge clock, asynchronous active-low reset
//   start              run request, only looked at while idle
//   entry[31:0]        first PC of the run, loaded on an accepted start
//   count[7:0]         instructions to run; zero only produces a done pulse
//   ins[31:0]          instruction from the fetch stage
//   pcp4[31:0]         PC+4 from the fetch stage
//   imm[31:0]          sign-extended immediate from decode
//   zero               ALU zero flag, used by beq at write-back
//   pc[31:0]           current PC
//   if_en              instruction-register load strobe (FETCH cycle)
//   reg_dst, alu_src   registered datapath controls
//   alu_op[2:0]        registered ALU operation select
//   reg_we             register-file write strobe (WB cycle)
//   busy               high whenever not idle
//   done               one-cycle pulse on the first idle cycle after a run
//   retired[7:0]       instructions completed in the current/last run
// -----------------------------------------------------------------------------
module y_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] entry,
  input  logic [7:0]  count,
  input  logic [31:0] ins,
  input  logic [31:0] pcp4,
  input  logic [31:0] imm,
  input  logic        zero,
  output logic [31:0] pc,
  output logic        if_en,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        reg_we,
  output logic [2:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic [7:0]  retired
);

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  remaining_q;
  logic        wr_q;
  logic        is_beq_q, is_j_q, is_halt_q;

  // Opcode decode, consumed only in DECODE.
  logic        dec_reg_dst, dec_alu_src, dec_wr;
  logic [2:0]  dec_alu_op;
  logic [5:0]  opcode;
  logic [31:0] pc_next;

  assign opcode = ins[31:26];

  // NOTE: every always_comb output gets a default before the case so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dec_reg_dst = 1'b0;
    dec_alu_src = 1'b1;
    dec_wr      = 1'b1;
    dec_alu_op  = ALU_ADD;
    unique case (opcode)
      OP_R: begin
        dec_reg_dst = 1'b1;
        dec_alu_src = 1'b0;
      end
      OP_J:    dec_wr = 1'b0;
      OP_BEQ: begin
        dec_alu_src = 1'b0;
        dec_wr      = 1'b0;
        dec_alu_op  = ALU_SUB;
      end
      OP_SW:   dec_wr = 1'b0;
      OP_HALT: begin
        dec_alu_src = 1'b0;
        dec_wr      = 1'b0;
        dec_alu_op  = 3'b000;
      end
      default: ;
    endcase
  end

  // Write-back PC selection; branch offset wraps modulo 2^32.
  always_comb begin
    pc_next = pcp4;
    if (is_beq_q && zero) begin
      pc_next = pcp4 + {imm[29:0], 2'b00};
    end else if (is_j_q) begin
      pc_next = {pcp4[31:28], ins[25:0], 2'b00};
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start && (count != 8'd0)) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = (is_halt_q || (remaining_q == 8'd1)) ? S_IDLE : S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the reset branch clears every register here, since a reset mid-run
  // must leave no stale control or count behind for the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      remaining_q <= '0;
      retired     <= '0;
      done        <= 1'b0;
      reg_dst     <= 1'b0;
      alu_src     <= 1'b0;
      alu_op      <= '0;
      wr_q        <= 1'b0;
      is_beq_q    <= 1'b0;
      is_j_q      <= 1'b0;
      is_halt_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            retired <= '0;
            if (count != 8'd0) begin
              pc          <= entry;
              remaining_q <= count;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_DECODE: begin
          reg_dst   <= dec_reg_dst;
          alu_src   <= dec_alu_src;
          alu_op    <= dec_alu_op;
          wr_q      <= dec_wr;
          is_beq_q  <= (opcode == OP_BEQ);
          is_j_q    <= (opcode == OP_J);
          is_halt_q <= (opcode == OP_HALT);
        end
        S_WB: begin
          pc          <= pc_next;
          remaining_q <= remaining_q - 8'd1;
          if (retired != 8'hFF) retired <= retired + 8'd1;
          // Controls drop after write-back so they read zero outside EXEC/WB.
          reg_dst     <= 1'b0;
          alu_src     <= 1'b0;
          alu_op      <= '0;
          wr_q        <= 1'b0;
          is_beq_q    <= 1'b0;
          is_j_q      <= 1'b0;
          is_halt_q   <= 1'b0;
          done        <= (state_d == S_IDLE);
        end
        default: ;
      endcase
    end
  end

  assign if_en  = (state_q == S_FETCH);
  assign reg_we = (state_q == S_WB) && wr_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_y_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_y_seq_ctrl
//   Each run is expanded up front into a per-cycle trace of expected outputs:
//   instruction k occupies cycles 4k+1..4k+4 after the start cycle, the PC and
//   retired count advance per instruction, and the run ends with one done
//   cycle. A single negedge process compares the DUT to the current trace
//   entry. Directed runs add literal end-state expectations.
// -----------------------------------------------------------------------------
module tb_y_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] entry;
  logic [7:0]  count;
  logic [31:0] ins, pcp4, imm;
  logic        zero;
  logic [31:0] pc;
  logic        if_en, reg_dst, alu_src, reg_we, busy, done;
  logic [2:0]  alu_op;
  logic [7:0]  retired;

  y_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .entry(entry), .count(count),
    .ins(ins), .pcp4(pcp4), .imm(imm), .zero(zero), .pc(pc), .if_en(if_en),
    .reg_dst(reg_dst), .alu_src(alu_src), .reg_we(reg_we), .alu_op(alu_op),
    .busy(busy), .done(done), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        if_en, reg_we, busy, done, ctrl_chk, reg_dst, alu_src;
    logic [2:0]  alu_op;
    logic [7:0]  retired;
  } exp_t;

  typedef struct {
    logic [31:0] ins, pcp4, imm;
    logic        zero, idle;
  } stim_t;

  exp_t        exp_q[$];
  stim_t       stim_q[$];
  logic [31:0] prog_q[$];
  logic [31:0] imm_q[$];
  logic        zero_q[$];

  exp_t        exp_cur;
  logic        exp_valid = 1'b0;
  logic [31:0] m_pc  = '0;
  logic [7:0]  m_ret = '0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Control table straight from the opcode list.
  function automatic void decode(input logic [5:0] op, output logic rd,
                                 output logic as, output logic wr, output logic [2:0] aop);
    case (op)
      6'd0:  begin rd = 1; as = 0; wr = 1; aop = 3'b010; end
      6'd2:  begin rd = 0; as = 1; wr = 0; aop = 3'b010; end
      6'd4:  begin rd = 0; as = 0; wr = 0; aop = 3'b110; end
      6'd43: begin rd = 0; as = 1; wr = 0; aop = 3'b010; end
      6'd63: begin rd = 0; as = 0; wr = 0; aop = 3'b000; end
      default: begin rd = 0; as = 1; wr = 1; aop = 3'b010; end
    endcase
  endfunction

  function automatic exp_t idle_exp(input logic [31:0] p, input logic [7:0] r, input logic d);
    exp_t e;
    e.pc = p; e.if_en = 0; e.reg_we = 0; e.busy = 0; e.done = d;
    e.ctrl_chk = 1; e.reg_dst = 0; e.alu_src = 0; e.alu_op = 3'b000; e.retired = r;
    return e;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.ins = $urandom; s.pcp4 = $urandom; s.imm = $urandom; s.zero = 1'($urandom);
    s.idle = 1;
    return s;
  endfunction

  // Expand one run (entry, n, prog_q/imm_q/zero_q) into the expected trace.
  task automatic build_run(input logic [31:0] e_pc, input logic [7:0] n);
    logic [31:0] p, p4;
    logic [7:0]  rem, ret;
    logic [5:0]  op;
    logic        rd, as, wr;
    logic [2:0]  aop;
    exp_t        e;
    stim_t       s;
    exp_q.delete();
    stim_q.delete();
    if (n == 0) begin
      m_ret = 0;
      exp_q.push_back(idle_exp(m_pc, 8'd0, 1'b1)); stim_q.push_back(idle_stim());
      exp_q.push_back(idle_exp(m_pc, 8'd0, 1'b0)); stim_q.push_back(idle_stim());
      return;
    end
    p = e_pc; rem = n; ret = 0;
    for (int k = 0; k < int'(n); k++) begin
      op = prog_q[k][31:26];
      decode(op, rd, as, wr, aop);
      p4 = p + 32'd4;
      for (int ph = 0; ph < 4; ph++) begin
        e.pc = p; e.if_en = (ph == 0); e.reg_we = (ph == 3) && wr; e.busy = 1;
        e.done = 0; e.ctrl_chk = (ph >= 2); e.reg_dst = rd; e.alu_src = as;
        e.alu_op = aop; e.retired = ret;
        exp_q.push_back(e);
        s.ins = prog_q[k]; s.pcp4 = p4; s.imm = imm_q[k]; s.zero = zero_q[k]; s.idle = 0;
        stim_q.push_back(s);
      end
      if (op == 6'd4 && zero_q[k]) p = p4 + {imm_q[k][29:0], 2'b00};
      else if (op == 6'd2)         p = {p4[31:28], prog_q[k][25:0], 2'b00};
      else                         p = p4;
      if (ret != 8'hFF) ret = ret + 1;
      rem = rem - 1;
      if (op == 6'd63 || rem == 0) break;
    end
    exp_q.push_back(idle_exp(p, ret, 1'b1)); stim_q.push_back(idle_stim());
    exp_q.push_back(idle_exp(p, ret, 1'b0)); stim_q.push_back(idle_stim());
    m_pc = p; m_ret = ret;
  endtask

  // Drive the start cycle, then up to `limit` traced cycles.
  task automatic do_run(input logic [31:0] e_pc, input logic [7:0] n, input int limit);
    build_run(e_pc, n);
    @(posedge clk); #1;
    exp_valid = 0;
    start = 1; entry = e_pc; count = n;
    for (int i = 0; i < exp_q.size() && i < limit; i++) begin
      @(posedge clk); #1;
      // Random start/entry/count while busy must be ignored.
      start = stim_q[i].idle ? 1'b0 : 1'($urandom);
      entry = $urandom; count = 8'($urandom);
      ins = stim_q[i].ins; pcp4 = stim_q[i].pcp4;
      imm = stim_q[i].imm; zero = stim_q[i].zero;
      exp_cur = exp_q[i];
      exp_valid = 1;
    end
    @(negedge clk); #1;
    exp_valid = 0;
    start = 0;
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check("pc", pc, exp_cur.pc);
      check("if_en", if_en, exp_cur.if_en);
      check("reg_we", reg_we, exp_cur.reg_we);
      check("busy", busy, exp_cur.busy);
      check("done", done, exp_cur.done);
      check("retired", retired, exp_cur.retired);
      check("done_and_if_en", done & if_en, 1'b0);
      if (exp_cur.ctrl_chk) begin
        check("reg_dst", reg_dst, exp_cur.reg_dst);
        check("alu_src", alu_src, exp_cur.alu_src);
        check("alu_op", alu_op, exp_cur.alu_op);
      end
    end
  end

  task automatic set_prog(input int n);
    logic [5:0] ops[6];
    logic [5:0] op;
    ops[0] = 6'd0; ops[1] = 6'd2; ops[2] = 6'd4; ops[3] = 6'd43; ops[4] = 6'd63; ops[5] = 6'd17;
    prog_q.delete(); imm_q.delete(); zero_q.delete();
    for (int k = 0; k < n; k++) begin
      op = ($urandom_range(0, 9) == 0) ? ops[4] : ops[$urandom_range(0, 5)];
      if (op == 6'd63 && $urandom_range(0, 1) == 0) op = 6'd0;
      prog_q.push_back({op, 26'($urandom)});
      imm_q.push_back($urandom);
      zero_q.push_back(1'($urandom));
    end
  endtask

  task automatic set_one(input logic [31:0] i0, input logic [31:0] im, input logic z);
    prog_q.delete(); imm_q.delete(); zero_q.delete();
    prog_q.push_back(i0); imm_q.push_back(im); zero_q.push_back(z);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0; start = 0; entry = 0; count = 0; ins = 0; pcp4 = 0; imm = 0; zero = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_pc", pc, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_retired", retired, 8'd0);

    // Three R-type instructions from 128.
    set_one({6'd0, 26'h0123456}, 32'd0, 1'b0);
    prog_q.push_back({6'd0, 26'h0000AAA}); imm_q.push_back(0); zero_q.push_back(0);
    prog_q.push_back({6'd0, 26'h3FFFFFF}); imm_q.push_back(0); zero_q.push_back(1);
    build_run(32'd128, 8'd3);
    check("model_if_en_c1", exp_q[0].if_en, 1'b1);
    check("model_if_en_c9", exp_q[8].if_en, 1'b1);
    check("model_reg_we_c12", exp_q[11].reg_we, 1'b1);
    check("model_done_c13", exp_q[12].done, 1'b1);
    do_run(32'd128, 8'd3, 1000);
    check("r3_pc", pc, 32'd140);
    check("r3_retired", retired, 8'd3);

    // beq taken: pcp4=136, imm=2 -> 144.
    set_one({6'd4, 26'd0}, 32'd2, 1'b1);
    do_run(32'd132, 8'd1, 1000);
    check("beq_pc", pc, 32'd144);

    // j: pcp4=0x84, target field 0x20 -> 0x80.
    set_one({6'd2, 26'h20}, 32'd0, 1'b0);
    do_run(32'h80, 8'd1, 1000);
    check("j_pc", pc, 32'h80);

    // Halt as second of ten.
    set_one({6'd0, 26'd5}, 32'd0, 1'b0);
    prog_q.push_back({6'd63, 26'd0}); imm_q.push_back(0); zero_q.push_back(0);
    for (int k = 2; k < 10; k++) begin
      prog_q.push_back({6'd0, 26'd0}); imm_q.push_back(0); zero_q.push_back(0);
    end
    do_run(32'h1000, 8'd10, 1000);
    check("halt_retired", retired, 8'd2);
    check("halt_pc", pc, 32'h1008);
    check("halt_busy", busy, 1'b0);

    // count=0: done only.
    do_run(32'h2000, 8'd0, 1000);
    check("cnt0_retired", retired, 8'd0);
    check("cnt0_busy", busy, 1'b0);

    // Reset during EXEC of the second of three (cycle 7).
    set_prog(3);
    for (int k = 0; k < 3; k++) prog_q[k] = {6'd0, 26'($urandom)};
    do_run(32'd256, 8'd3, 7);
    #1 rst_n = 0;
    #1;
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_reg_we", reg_we, 1'b0);
    check("mid_rst_if_en", if_en, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_retired", retired, 8'd0);
    check("mid_rst_ctrl", {reg_dst, alu_src, alu_op}, 5'd0);
    m_pc = 0; m_ret = 0;
    @(posedge clk); #1 rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_quiet", {busy, reg_we, done}, 3'b000);
    end
    set_prog(3);
    for (int k = 0; k < 3; k++) prog_q[k] = {6'd0, 26'($urandom)};
    do_run(32'd256, 8'd3, 1000);
    check("post_rst_pc", pc, 32'd268);

    // Randomized runs.
    for (int r = 0; r < 40; r++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      set_prog(n);
      do_run({$urandom_range(0, 32'h3FFFFFFF), 2'b00}, 8'(n), 1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
